// File: rtl/arb_pkg.sv
// Shared types for the dual-core RAM port arbiter.
// Imported by the arbiter top and its grant selector.
package arb_pkg;

    typedef enum logic {IDLE, ACCESS} arb_state_t;

    typedef enum logic [1:0] {IREAD, DREAD, DWRITE} req_type_t;

    typedef logic [31:0] word_t;

    localparam int NUM_CORES = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
// master: the arbiter; slave: cores plus RAM model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]             iren;
    logic [1:0][ADDR_W-1:0] iaddr;
    logic [1:0]             dren;
    logic [1:0]             dwen;
    logic [1:0][ADDR_W-1:0] daddr;
    logic [1:0][DATA_W-1:0] dstore;
    logic [1:0]             iwait;
    logic [1:0]             dwait;
    logic [DATA_W-1:0]      iload;
    logic [DATA_W-1:0]      dload;
    logic                   ram_ren;
    logic                   ram_wen;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_store;
    logic [DATA_W-1:0]      ram_load;
    logic                   ram_ready;

    modport master (
        input  iren, iaddr, dren, dwen,
        input  daddr, dstore,
        input  ram_load, ram_ready,
        output iwait, dwait, iload, dload,
        output ram_ren, ram_wen,
        output ram_addr, ram_store
    );

    modport slave (
        output iren, iaddr, dren, dwen,
        output daddr, dstore,
        output ram_load, ram_ready,
        input  iwait, dwait, iload, dload,
        input  ram_ren, ram_wen,
        input  ram_addr, ram_store
    );
endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Combinational grant pick: round-robin between cores,
// data-before-instruction and write-before-read inside a core.
module rr_select
    import arb_pkg::*;
(
    input  logic [NUM_CORES-1:0] iren,
    input  logic [NUM_CORES-1:0] dren,
    input  logic [NUM_CORES-1:0] dwen,
    input  logic                 rr_ptr,
    output logic                 core,
    output req_type_t            rtype,
    output logic                 valid
);

    logic [NUM_CORES-1:0] req;

    assign req   = iren | dren | dwen;
    assign valid = |req;

    always_comb begin
        core = 1'b0;
        if (&req) begin
            core = rr_ptr;
        end else begin
            core = req[1];
        end
    end

    always_comb begin
        rtype = IREAD;
        if (dwen[core]) begin
            rtype = DWRITE;
        end else if (dren[core]) begin
            rtype = DREAD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core RAM port arbiter: latches one request,
// holds the RAM strobe until ram_ready, then completes.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);

    arb_state_t        state;
    logic              rr_ptr;
    logic              g_core;
    req_type_t         g_type;
    logic              ren_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;

    logic              sel_core;
    logic              sel_valid;
    req_type_t         sel_type;
    logic              fin;
    logic [1:0]        idone;
    logic [1:0]        ddone;

    rr_select u_sel (
        .iren   (bus.iren),
        .dren   (bus.dren),
        .dwen   (bus.dwen),
        .rr_ptr (rr_ptr),
        .core   (sel_core),
        .rtype  (sel_type),
        .valid  (sel_valid)
    );

    assign fin = (state == ACCESS) && bus.ram_ready;

    // Completion goes only to the latched requester and type.
    always_comb begin
        idone = 2'b00;
        ddone = 2'b00;
        if (fin) begin
            if (g_type == IREAD) begin
                idone[g_core] = 1'b1;
            end else begin
                ddone[g_core] = 1'b1;
            end
        end
    end

    assign bus.iwait = bus.iren & ~idone;
    assign bus.dwait = (bus.dren | bus.dwen) & ~ddone;
    assign bus.iload = bus.ram_load;
    assign bus.dload = bus.ram_load;

    assign bus.ram_ren   = ren_q;
    assign bus.ram_wen   = wen_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_store = store_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            g_core  <= 1'b0;
            g_type  <= IREAD;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state   <= ACCESS;
                        g_core  <= sel_core;
                        g_type  <= sel_type;
                        ren_q   <= (sel_type != DWRITE);
                        wen_q   <= (sel_type == DWRITE);
                        addr_q  <= (sel_type == IREAD)
                                 ? bus.iaddr[sel_core]
                                 : bus.daddr[sel_core];
                        store_q <= bus.dstore[sel_core];
                    end
                end
                ACCESS: begin
                    if (bus.ram_ready) begin
                        state  <= IDLE;
                        rr_ptr <= ~g_core;
                        ren_q  <= 1'b0;
                        wen_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected RAM accesses
// are queued with the stimulus and checked as the DUT grants.
module tb_mem_arbiter;

    typedef struct {
        int          core;
        int          kind;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    logic CLK;
    logic nRST;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_reqs();
        bus.iren   = '0;
        bus.dren   = '0;
        bus.dwen   = '0;
        bus.iaddr  = '0;
        bus.daddr  = '0;
        bus.dstore = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic push(input int c, input int k,
                        input logic [31:0] a,
                        input logic [31:0] s);
        exp_t e;
        e.core  = c;
        e.kind  = k;
        e.addr  = a;
        e.store = s;
        sb.push_back(e);
    endtask

    // Waits for a grant, checks it against the queue head,
    // then answers after lat cycles with the given load.
    task automatic serve(input int lat, input logic [31:0] load);
        exp_t e;
        int   n;
        logic w;
        logic [31:0] ld;
        n = 0;
        #3;
        while (!(bus.ram_ren || bus.ram_wen) && n < 20) begin
            tick();
            #3;
            n++;
        end
        vectors++;
        if (n >= 20) begin
            $display("FAIL grant_timeout: no strobe, want one");
            miscompares++;
            return;
        end
        if (sb.size() == 0) begin
            $display("FAIL sb_empty: strobe %b%b, want none",
                     bus.ram_ren, bus.ram_wen);
            miscompares++;
            return;
        end
        e = sb.pop_front();
        if ({bus.ram_ren, bus.ram_wen, bus.ram_addr} !==
            {e.kind != 2, e.kind == 2, e.addr}) begin
            $display("FAIL grant: got ren=%b wen=%b addr=%h want ren=%b wen=%b addr=%h",
                     bus.ram_ren, bus.ram_wen, bus.ram_addr,
                     e.kind != 2, e.kind == 2, e.addr);
            miscompares++;
        end
        if (e.kind == 2) begin
            vectors++;
            if (bus.ram_store !== e.store) begin
                $display("FAIL store: got %h want %h",
                         bus.ram_store, e.store);
                miscompares++;
            end
        end
        for (int i = 1; i < lat; i++) begin
            w = (e.kind == 0) ? bus.iwait[e.core] : bus.dwait[e.core];
            vectors++;
            if (w !== 1'b1) begin
                $display("FAIL wait_hold: got %b want 1", w);
                miscompares++;
            end
            tick();
            #3;
            vectors++;
            if (bus.ram_addr !== e.addr) begin
                $display("FAIL addr_hold: got %h want %h",
                         bus.ram_addr, e.addr);
                miscompares++;
            end
        end
        bus.ram_ready = 1'b1;
        bus.ram_load  = load;
        #1;
        w  = (e.kind == 0) ? bus.iwait[e.core] : bus.dwait[e.core];
        ld = (e.kind == 0) ? bus.iload : bus.dload;
        vectors++;
        if (w !== 1'b0) begin
            $display("FAIL done_wait: got %b want 0", w);
            miscompares++;
        end
        if (e.kind != 2) begin
            vectors++;
            if (ld !== load) begin
                $display("FAIL load: got %h want %h", ld, load);
                miscompares++;
            end
        end
        tick();
        bus.ram_ready = 1'b0;
        vectors++;
        if ({bus.ram_ren, bus.ram_wen} !== 2'b00) begin
            $display("FAIL idle_strobe: got %b%b want 00",
                     bus.ram_ren, bus.ram_wen);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        bus.iren = 2'b11;
        bus.dren = 2'b11;
        bus.dwen = 2'b11;
        bus.iaddr[0] = 32'h44;
        bus.daddr[1] = 32'h88;
        tick();
        tick();
        bus.ram_ready = 1'b1;
        #1;
        vectors++;
        if ({bus.ram_ren, bus.ram_wen, bus.ram_addr} !== 34'd0) begin
            $display("FAIL reset_ram: got ren=%b wen=%b addr=%h want 0 0 0",
                     bus.ram_ren, bus.ram_wen, bus.ram_addr);
            miscompares++;
        end
        vectors++;
        if ({bus.iwait, bus.dwait} !== 4'b1111) begin
            $display("FAIL reset_wait: got %b%b want 1111",
                     bus.iwait, bus.dwait);
            miscompares++;
        end
        tick();
        bus.ram_ready = 1'b0;
        clear_reqs();
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        bus.iren[0]  = 1'b1;
        bus.iaddr[0] = 32'h40;
        push(0, 0, 32'h40, 32'h0);
        serve(3, 32'hDEADBEEF);
        clear_reqs();
        tick();
        vectors++;
        if ({bus.ram_ren, bus.ram_wen} !== 2'b00) begin
            $display("FAIL single_idle: got %b%b want 00",
                     bus.ram_ren, bus.ram_wen);
            miscompares++;
        end
    endtask

    task automatic test_contention();
        nRST         = 1'b0;
        bus.dren     = 2'b11;
        bus.daddr[0] = 32'h100;
        bus.daddr[1] = 32'h200;
        tick();
        push(0, 1, 32'h100, 32'h0);
        push(1, 1, 32'h200, 32'h0);
        push(0, 1, 32'h100, 32'h0);
        nRST = 1'b1;
        serve(1, 32'h11111111);
        serve(2, 32'h22222222);
        serve(1, 32'h33333333);
        clear_reqs();
    endtask

    task automatic test_intra_priority();
        do_reset();
        bus.iren[1]   = 1'b1;
        bus.iaddr[1]  = 32'h80;
        bus.dwen[1]   = 1'b1;
        bus.daddr[1]  = 32'h300;
        bus.dstore[1] = 32'h1234;
        push(1, 2, 32'h300, 32'h1234);
        push(1, 0, 32'h80, 32'h0);
        serve(2, 32'h0);
        bus.dwen[1] = 1'b0;
        serve(1, 32'hCAFEF00D);
        clear_reqs();
    endtask

    task automatic test_rw_both();
        do_reset();
        bus.dren[0]   = 1'b1;
        bus.dwen[0]   = 1'b1;
        bus.daddr[0]  = 32'h10;
        bus.dstore[0] = 32'hAA;
        push(0, 2, 32'h10, 32'hAA);
        serve(1, 32'h0);
        clear_reqs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.dren[1]  = 1'b1;
        bus.daddr[1] = 32'h700;
        push(1, 1, 32'h700, 32'h0);
        push(1, 1, 32'h700, 32'h0);
        serve(1, 32'h0BADC0DE);
        serve(2, 32'h12345678);
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dwen[1]   = 1'b1;
        bus.daddr[1]  = 32'h500;
        bus.dstore[1] = 32'h55;
        tick();
        vectors++;
        if (bus.ram_wen !== 1'b1) begin
            $display("FAIL mid_grant: got wen=%b want 1", bus.ram_wen);
            miscompares++;
        end
        nRST = 1'b0;
        tick();
        vectors++;
        if ({bus.ram_ren, bus.ram_wen, bus.ram_addr} !== 34'd0) begin
            $display("FAIL mid_abort: got ren=%b wen=%b addr=%h want 0 0 0",
                     bus.ram_ren, bus.ram_wen, bus.ram_addr);
            miscompares++;
        end
        bus.ram_ready = 1'b1;
        #1;
        vectors++;
        if (bus.dwait[1] !== 1'b1) begin
            $display("FAIL mid_no_done: got %b want 1", bus.dwait[1]);
            miscompares++;
        end
        tick();
        bus.ram_ready = 1'b0;
        nRST          = 1'b1;
        bus.dren[0]   = 1'b1;
        bus.daddr[0]  = 32'h600;
        push(0, 1, 32'h600, 32'h0);
        push(1, 2, 32'h500, 32'h55);
        serve(1, 32'h66666666);
        bus.dren[0] = 1'b0;
        serve(1, 32'h0);
        clear_reqs();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        nRST          = 1'b0;
        bus.ram_ready = 1'b0;
        bus.ram_load  = '0;
        clear_reqs();
        tick();
        test_reset();
        test_single_read();
        test_contention();
        test_intra_priority();
        test_rw_both();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the two cores of the dual-core MIPS CPU.
- Each core presents one instruction-fetch request and one data request (read or write).
- The block selects one requester, latches that requester's address and data, holds the RAM handshake until ram_ready, then returns completion.
- Sits between the per-core cache/fetch interfaces and the RAM model.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 32, RAM data width.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset, synchronous, active-low.
- iren  input  [1:0]  instruction read request, per core.
- iaddr  input  [1:0][ADDR_W-1:0]  instruction address, per core.
- dren  input  [1:0]  data read request, per core.
- dwen  input  [1:0]  data write request, per core.
- daddr  input  [1:0][ADDR_W-1:0]  data address, per core.
- dstore  input  [1:0][DATA_W-1:0]  write data, per core.
- iwait  output  [1:0]  instruction request pending, not completing this cycle.
- dwait  output  [1:0]  data request pending, not completing this cycle.
- iload  output  [DATA_W-1:0]  read data; equals ram_load.
- dload  output  [DATA_W-1:0]  read data; equals ram_load.
- ram_ren  output  1  RAM read strobe.
- ram_wen  output  1  RAM write strobe.
- ram_addr  output  ADDR_W  RAM address.
- ram_store  output  DATA_W  RAM write data.
- ram_load  input  DATA_W  RAM read data.
- ram_ready  input  1  RAM access complete; single-cycle pulse; variable latency of 1 or more ACCESS cycles.

Behaviour:
- Reset, applied at the clock edge while nRST=0:
  - state=IDLE, rr_ptr=0 (core 0 preferred).
  - Latched grant registers cleared.
  - ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0.
  - Reset mid-ACCESS abandons the transaction; no completion is signalled.
- Wait outputs (combinational):
  - iwait[c] = iren[c] & ~idone[c].
  - dwait[c] = (dren[c]|dwen[c]) & ~ddone[c].
  - idone/ddone are high only in the cycle ram_ready=1 in ACCESS, and only for the granted requester and type.
- Request type per core:
  - dwen beats dren (dwen=dren=1 is treated as a write).
  - Data beats instruction within a core.
- FSM, states IDLE and ACCESS:
  - IDLE: if no requests, stay; all RAM strobes 0.
  - IDLE with requests: pick a core. If both cores request, take core rr_ptr; otherwise take the one requesting.
  - On the clock edge, latch core, type (IREAD/DREAD/DWRITE), address and store data, then go to ACCESS.
  - ACCESS: ram_ren = (type != DWRITE); ram_wen = (type == DWRITE); ram_addr and ram_store come from the latches.
  - Requester inputs are ignored during ACCESS.
  - ACCESS with ram_ready=0: hold all outputs, stay.
  - ACCESS with ram_ready=1: signal completion combinationally; iload/dload carry ram_load this cycle. Set rr_ptr to ~granted core and go to IDLE.
- Latency:
  - Minimum: request seen in cycle N, RAM strobed in N+1, completion in N+1 if ram_ready=1 immediately.
  - One IDLE cycle always separates consecutive transactions.
- Fairness:
  - Alternation applies only when both cores are requesting.
  - A lone requester is granted back-to-back.
  - Priority is data-before-instruction inside a core, so one core's instruction fetch can wait behind its own data, never behind the other core's repeated requests.
- Requester drops its request during ACCESS: the RAM transaction still completes with the latched values; no wait bit is affected because that request is now 0.
- ram_ready in IDLE is ignored.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {IDLE, ACCESS} arb_state_t.
  - typedef enum logic [1:0] {IREAD, DREAD, DWRITE} req_type_t.
  - word_t = logic [31:0].
  - Constant NUM_CORES = 2.
- Sub-module rr_select (combinational): inputs are per-core request vectors and rr_ptr; outputs are the granted core, req_type and a valid bit. mem_arbiter holds the FSM, latches and wait logic.

Test Plan:
- Reset: hold nRST=0 with all requests asserted -> ram_ren=ram_wen=0, ram_addr=0; all wait bits=1 (no completion).
- Single read: core0 iren, iaddr=0x40, RAM ready after 3 cycles with load 0xDEADBEEF -> ram_ren=1, ram_addr=0x40 for 3 cycles. iwait[0]=0 and iload=0xDEADBEEF in the ready cycle, then IDLE.
- Contention: both cores assert dren continuously from reset, daddr 0x100/0x200 -> grants alternate core0, core1, core0; ram_addr sequence is 0x100, 0x200, 0x100.
- Intra-core priority: core1 asserts iren (0x80) and dwen (0x300, store 0x1234) together -> write is granted first (ram_wen=1, ram_store=0x1234), then read of 0x80.
- Simultaneous dren and dwen: core0 both high at 0x10 -> ram_wen=1, ram_ren=0.
- Reset mid-ACCESS: nRST=0 during a pending write, ram_ready=0 -> next cycle IDLE with strobes 0; a later ram_ready pulse causes no completion. After release, core0 is granted first.
